sram_like_responder: RTL and testbench

//  Slave (responder) end of the sram-like req/addr_ok/data_ok bus issued by the fetch and memory stages.

---
 rtl/sram_like_responder_pkg.sv | 15 +
 rtl/sram_like_responder_resp_fifo.sv | 63 ++++++
 rtl/sram_like_responder.sv | 93 +++++++++
 tb/tb_sram_like_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the sram-like responder and its bench.
//   SRAM_LIKE_*_W : bus widths of the req/addr_ok/data_ok interface
//   SRAM_LIKE_RESET_PC : core reset fetch address, reused by bench stimulus
//   pend_t : one-cycle pending stage between RAM access and response FIFO
package sram_like_responder_pkg;
    localparam int SRAM_LIKE_WEN_W  = 4;
    localparam int SRAM_LIKE_ADDR_W = 32;
    localparam int SRAM_LIKE_DATA_W = 32;
    localparam logic [SRAM_LIKE_ADDR_W-1:0] SRAM_LIKE_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic vld;  // a RAM access was issued last cycle
        logic wr;   // that access was a write (respond with 0)
    } pend_t;
endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// sram_resp_fifo: synchronous in-order response FIFO.
//   clk, resetn        : clock, async active-low reset (pointers/count only)
//   push, push_data    : enqueue one entry
//   pop                : dequeue head (ignored when empty)
//   empty, full        : occupancy flags
//   head_data          : entry at the head, valid when !empty
module sram_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-2 depths would also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: contents are only observed behind count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // The outstanding limit upstream makes this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
                                    !(push && full && !pop));
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: slave end of the sram-like req/addr_ok/data_ok bus.
// Accepts requests into a 1-cycle synchronous RAM and returns exactly one
// in-order data_ok per accepted request, optionally delayed at FIFO head.
//   clk, resetn                  : clock, async active-low reset
//   req, wen, addr, wdata        : request from master (wen==0 is a read)
//   addr_ok                      : request accepted when req && addr_ok
//   data_ok, rdata               : one response per cycle max, rdata 0 for writes
//   ram_en/ram_wen/ram_addr/ram_wdata, ram_rdata : RAM port, read data next cycle
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESP_DELAY = 0,
    parameter int RAM_AW     = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        req,
    input  logic [SRAM_LIKE_WEN_W-1:0]  wen,
    input  logic [SRAM_LIKE_ADDR_W-1:0] addr,
    input  logic [SRAM_LIKE_DATA_W-1:0] wdata,
    output logic                        addr_ok,
    output logic                        data_ok,
    output logic [SRAM_LIKE_DATA_W-1:0] rdata,
    output logic                        ram_en,
    output logic [SRAM_LIKE_WEN_W-1:0]  ram_wen,
    output logic [RAM_AW-1:0]           ram_addr,
    output logic [SRAM_LIKE_DATA_W-1:0] ram_wdata,
    input  logic [SRAM_LIKE_DATA_W-1:0] ram_rdata
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int WW = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;

    logic [OW-1:0]               outstanding;
    logic [WW-1:0]               wait_cnt;
    pend_t                       pend;
    logic                        accept;
    logic                        fifo_empty, fifo_full;
    logic [SRAM_LIKE_DATA_W-1:0] head_data, push_data;

    // Outstanding covers the pending stage as well as the FIFO, so a full
    // count blocks acceptance before the FIFO can ever overflow. A pop in
    // the full cycle only frees a slot from the next cycle on.
    assign addr_ok = resetn && (outstanding < OW'(DEPTH));
    assign accept  = req && addr_ok;

    assign ram_en    = accept;
    assign ram_wen   = accept ? wen : '0;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    assign push_data = pend.wr ? '0 : ram_rdata;

    sram_resp_fifo #(.WIDTH(SRAM_LIKE_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (pend.vld),
        .push_data (push_data),
        .pop       (data_ok),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head_data (head_data)
    );

    assign data_ok = resetn && !fifo_empty && (wait_cnt == WW'(RESP_DELAY));
    assign rdata   = data_ok ? head_data : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend        <= '0;
            outstanding <= '0;
            wait_cnt    <= '0;
        end else begin
            pend.vld <= accept;
            pend.wr  <= accept && (wen != '0);
            case ({accept, data_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            // Each new head waits a fresh RESP_DELAY cycles after a pop.
            if (data_ok)          wait_cnt <= '0;
            else if (!fifo_empty) wait_cnt <= wait_cnt + WW'(1);
        end
    end

    logic unused_bits;
    if (RAM_AW < 30) begin : g_unused_hi
        assign unused_bits = ^{addr[1:0], addr[31:RAM_AW+2], fifo_full};
    end else begin : g_unused_lo
        assign unused_bits = ^{addr[1:0], fifo_full};
    end
endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;
    import sram_like_responder_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // fast instance: RESP_DELAY=0
    logic        req_f, addr_ok_f, data_ok_f, ram_en_f;
    logic [3:0]  wen_f, ram_wen_f;
    logic [31:0] addr_f, wdata_f, rdata_f, ram_wdata_f, ram_rdata_f;
    logic [AW-1:0] ram_addr_f;
    // slow instance: RESP_DELAY=3
    logic        req_s, addr_ok_s, data_ok_s, ram_en_s;
    logic [3:0]  wen_s, ram_wen_s;
    logic [31:0] addr_s, wdata_s, rdata_s, ram_wdata_s, ram_rdata_s;
    logic [AW-1:0] ram_addr_s;

    sram_like_responder #(.DEPTH(4), .RESP_DELAY(0), .RAM_AW(AW)) u_dut (
        .clk(clk), .resetn(resetn), .req(req_f), .wen(wen_f), .addr(addr_f),
        .wdata(wdata_f), .addr_ok(addr_ok_f), .data_ok(data_ok_f), .rdata(rdata_f),
        .ram_en(ram_en_f), .ram_wen(ram_wen_f), .ram_addr(ram_addr_f),
        .ram_wdata(ram_wdata_f), .ram_rdata(ram_rdata_f));

    sram_like_responder #(.DEPTH(4), .RESP_DELAY(3), .RAM_AW(AW)) u_slow (
        .clk(clk), .resetn(resetn), .req(req_s), .wen(wen_s), .addr(addr_s),
        .wdata(wdata_s), .addr_ok(addr_ok_s), .data_ok(data_ok_s), .rdata(rdata_s),
        .ram_en(ram_en_s), .ram_wen(ram_wen_s), .ram_addr(ram_addr_s),
        .ram_wdata(ram_wdata_s), .ram_rdata(ram_rdata_s));

    int n_chk = 0;
    int n_fail = 0;
    int n_acc_f = 0;
    int n_dok_f = 0;
    logic init_go;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : {8'hA5, 8'(i), 8'h5A, 8'(i)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM models: read-first synchronous, byte write enables
    logic [31:0] mem_f [256];
    logic [31:0] mem_s [256];
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < 256; i++) begin
                mem_f[i] <= init_word(i);
                mem_s[i] <= init_word(i);
            end
        end else begin
            if (ram_en_f) begin
                mem_f[ram_addr_f] <= merge(mem_f[ram_addr_f], ram_wdata_f, ram_wen_f);
                ram_rdata_f <= mem_f[ram_addr_f];
            end
            if (ram_en_s) begin
                mem_s[ram_addr_s] <= merge(mem_s[ram_addr_s], ram_wdata_s, ram_wen_s);
                ram_rdata_s <= mem_s[ram_addr_s];
            end
        end
    end

    // Scoreboards: expected response computed at accept time, in order
    logic [31:0] refmem [256];
    logic [31:0] q_f[$];
    logic [31:0] q_s[$];
    always @(negedge clk) begin
        if (init_go) for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
        if (!resetn) begin
            q_f.delete();
            q_s.delete();
        end else begin
            if (data_ok_f) begin
                n_dok_f++;
                if (q_f.size() == 0) chk("fast_spurious_dok", 32'd1, 32'd0);
                else chk("fast_rdata", rdata_f, q_f.pop_front());
            end
            if (req_f && addr_ok_f) begin
                n_acc_f++;
                if (wen_f != 4'd0) begin
                    q_f.push_back(32'd0);
                    refmem[addr_f[9:2]] = merge(refmem[addr_f[9:2]], wdata_f, wen_f);
                end else q_f.push_back(refmem[addr_f[9:2]]);
            end
            if (data_ok_s) begin
                if (q_s.size() == 0) chk("slow_spurious_dok", 32'd1, 32'd0);
                else chk("slow_rdata", rdata_s, q_s.pop_front());
            end
            if (req_s && addr_ok_s) q_s.push_back(init_word(int'(addr_s[9:2])));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        resetn = 1'b0; init_go = 1'b1;
        req_f = 1'b1; wen_f = '0; addr_f = '0; wdata_f = '0;
        req_s = 1'b0; wen_s = '0; addr_s = '0; wdata_s = '0;

        // reset state, req held high must not reach the RAM
        @(negedge clk);
        chk("rst_addr_ok", addr_ok_f, 1'b0);
        chk("rst_data_ok", data_ok_f, 1'b0);
        chk("rst_rdata", rdata_f, 32'd0);
        chk("rst_ram_en", ram_en_f, 1'b0);
        tick();
        init_go = 1'b0; req_f = 1'b0; resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_addr_ok", addr_ok_f, 1'b1);
        chk("idle_ram_en", ram_en_f, 1'b0);

        // single read of word 0x10
        tick();
        req_f = 1'b1; addr_f = 32'h40; wen_f = '0;
        @(negedge clk);
        chk("rd_ram_en", ram_en_f, 1'b1);
        chk("rd_ram_addr", 32'(ram_addr_f), 32'h10);
        chk("rd_ram_wen", 32'(ram_wen_f), 32'd0);
        tick();
        req_f = 1'b0;
        @(negedge clk);
        chk("rd_dok_t1", data_ok_f, 1'b0);
        tick();
        @(negedge clk);
        chk("rd_dok_t2", data_ok_f, 1'b1);
        chk("rd_data", rdata_f, 32'hDEADBEEF);

        // write low half then read back next cycle
        tick();
        req_f = 1'b1; addr_f = 32'h40; wen_f = 4'b0011; wdata_f = 32'h1234ABCD;
        @(negedge clk);
        chk("wr_ram_wen", 32'(ram_wen_f), 32'h3);
        tick();
        wen_f = '0;
        tick();
        req_f = 1'b0;
        @(negedge clk);
        chk("wr_ack_dok", data_ok_f, 1'b1);
        chk("wr_ack_data", rdata_f, 32'd0);
        tick();
        @(negedge clk);
        chk("raw_dok", data_ok_f, 1'b1);
        chk("raw_data", rdata_f, 32'hDEADABCD);
        tick();
        @(negedge clk);
        chk("empty_dok", data_ok_f, 1'b0);
        chk("empty_rdata", rdata_f, 32'd0);

        // streaming reads every cycle
        tick();
        req_f = 1'b1; addr_f = 32'h0; wen_f = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (c >= 2) begin
                chk("stream_aok", addr_ok_f, 1'b1);
                chk("stream_dok", data_ok_f, 1'b1);
                chk("stream_outstanding", 32'(n_acc_f - n_dok_f), 32'd2);
            end
            @(posedge clk);
            #1;
            addr_f = addr_f + 32'd4;
        end
        req_f = 1'b0;
        repeat (4) tick();

        // full: slow instance, req held high, addr advances on accept
        req_s = 1'b1; addr_s = '0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("full_aok", addr_ok_s, (c < 4) || c == 6 || c == 10 || c == 14);
            chk("full_dok", data_ok_s, c == 5 || c == 9 || c == 13 || c == 17);
            acc = addr_ok_s;
            @(posedge clk);
            #1;
            if (acc) addr_s = addr_s + 32'd4;
        end
        req_s = 1'b0;
        repeat (20) tick();
        chk("full_drained", 32'(q_s.size()), 32'd0);

        // reset with 3 outstanding on slow instance
        req_s = 1'b1; addr_s = 32'h20;
        for (int k = 0; k < 3; k++) begin
            tick();
            addr_s = addr_s + 32'd4;
        end
        req_s = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_aok_s", addr_ok_s, 1'b0);
        chk("mid_rst_dok_s", data_ok_s, 1'b0);
        chk("mid_rst_aok_f", addr_ok_f, 1'b0);
        repeat (2) tick();
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_no_dok", data_ok_s, 1'b0);
            chk("post_rst_aok", addr_ok_s, 1'b1);
        end

        // random traffic on fast instance
        for (int c = 0; c < 300; c++) begin
            tick();
            req_f   = ($urandom % 4) != 0;
            wen_f   = ($urandom % 2) ? 4'($urandom % 16) : 4'd0;
            addr_f  = {22'd0, 8'($urandom_range(0, 31)), 2'($urandom % 4)};
            wdata_f = (c == 0) ? SRAM_LIKE_RESET_PC : $urandom;
        end
        tick();
        req_f = 1'b0;
        repeat (10) tick();
        chk("rand_acc_eq_dok", 32'(n_acc_f - n_dok_f), 32'd0);
        chk("rand_q_empty", 32'(q_f.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
